// File: rtl/npc_axi_sram.sv
// AXI4 slave SRAM model with in-RTL storage, INCR/WRAP/FIXED bursts and SLVERR on
// out-of-range or oversized beats; read and write channels run independently.
module npc_axi_sram #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned       RD_LAT    = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                arvalid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                arready,
  input  logic                rready,
  output logic                rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  input  logic                awvalid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  output logic                awready,
  input  logic                wvalid,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  output logic                wready,
  input  logic                bready,
  output logic                bvalid,
  output logic [1:0]          bresp
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFS   = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LAT_W = $clog2(RD_LAT + 1) + 1;
  localparam logic [ADDR_W:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH * BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic beat_err(input logic [ADDR_W-1:0] a, input logic [2:0] size);
    return (a < BASE_ADDR) || ({1'b0, a} >= LIMIT) || (size > 3'(OFS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFS);
  endfunction

  // WRAP with an unsupported length falls through to INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    logic [3:0]        lw;
    step = ADDR_W'(1) << size;
    case (len)
      8'd1:    lw = 4'd1;
      8'd3:    lw = 4'd2;
      8'd7:    lw = 4'd3;
      8'd15:   lw = 4'd4;
      default: lw = 4'd0;
    endcase
    mask = (ADDR_W'(1) << ({1'b0, size} + lw)) - ADDR_W'(1);
    if (burst == 2'b00) return a;
    if (burst == 2'b10 && lw != 4'd0) return (a & ~mask) | ((a + step) & mask);
    return a + step;
  endfunction

  // Read channel
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  r_state_t          r_state;
  logic [ADDR_W-1:0] r_addr, r_next, ld_addr;
  logic [7:0]        r_len, r_cnt;
  logic [2:0]        r_size, ld_size;
  logic [1:0]        r_burst;
  logic [LAT_W-1:0]  r_lat;
  logic              ld_err;
  logic [DATA_W-1:0] ld_data;

  // Address of the beat about to be presented: the AR request itself, the
  // latched start address after a wait, or the successor of the current beat.
  always_comb begin
    r_next  = next_addr(r_addr, r_len, r_size, r_burst);
    ld_addr = r_addr;
    ld_size = r_size;
    if (r_state == R_IDLE) begin
      ld_addr = araddr;
      ld_size = arsize;
    end else if (r_state == R_DATA) begin
      ld_addr = r_next;
    end
    ld_err  = beat_err(ld_addr, ld_size);
    ld_data = ld_err ? '0 : mem[word_idx(ld_addr)];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
    end else begin
      case (r_state)
        R_IDLE: if (arvalid) begin
          r_addr  <= araddr;
          r_len   <= arlen;
          r_size  <= arsize;
          r_burst <= arburst;
          r_cnt   <= arlen;
          r_lat   <= LAT_W'(1);
          arready <= 1'b0;
          if (RD_LAT == 1) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rdata   <= ld_data;
            rresp   <= ld_err ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (arlen == 8'd0);
          end else begin
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_lat == LAT_W'(RD_LAT - 1)) begin
            r_state <= R_DATA;
            rvalid  <= 1'b1;
            rdata   <= ld_data;
            rresp   <= ld_err ? RESP_SLVERR : RESP_OKAY;
            rlast   <= (r_cnt == 8'd0);
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        R_DATA: if (rready) begin
          if (r_cnt == 8'd0) begin
            r_state <= R_IDLE;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            arready <= 1'b1;
          end else begin
            r_addr <= r_next;
            r_cnt  <= r_cnt - 8'd1;
            rdata  <= ld_data;
            rresp  <= ld_err ? RESP_SLVERR : RESP_OKAY;
            rlast  <= (r_cnt == 8'd1);
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write channel
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t          w_state;
  logic [ADDR_W-1:0] w_addr, w_next;
  logic [7:0]        w_len, w_cnt;
  logic [2:0]        w_size;
  logic [1:0]        w_burst;
  logic              w_err, w_err_next, w_beat_err, w_fire;
  logic [IDX_W-1:0]  w_idx;

  always_comb begin
    w_next     = next_addr(w_addr, w_len, w_size, w_burst);
    w_beat_err = beat_err(w_addr, w_size);
    w_idx      = word_idx(w_addr);
    w_fire     = (w_state == W_DATA) && wvalid && wready;
    w_err_next = w_err | w_beat_err | (wlast != (w_cnt == 8'd0));
  end

  always_ff @(posedge clock) begin
    if (!reset && w_fire && !w_beat_err) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: if (awvalid) begin
          w_addr  <= awaddr;
          w_len   <= awlen;
          w_size  <= awsize;
          w_burst <= awburst;
          w_cnt   <= awlen;
          w_err   <= 1'b0;
          awready <= 1'b0;
          wready  <= 1'b1;
          w_state <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          w_err <= w_err_next;
          if (w_cnt == 8'd0) begin
            wready  <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= w_err_next ? RESP_SLVERR : RESP_OKAY;
            w_state <= W_RESP;
          end else begin
            w_cnt  <= w_cnt - 8'd1;
            w_addr <= w_next;
          end
        end
        W_RESP: if (bready) begin
          bvalid  <= 1'b0;
          awready <= 1'b1;
          w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_npc_axi_sram.sv
// Scoreboard bench for npc_axi_sram: tasks queue expected R/B responses from a
// byte-level memory model; a negedge monitor pops and compares every handshake.
`timescale 1ns/1ps
module tb_npc_axi_sram;
  localparam int unsigned DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] LIMIT = BASE + 32'(DEPTH * 4);

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } rbeat_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        arvalid, arready, rready, rvalid, rlast;
  logic [31:0] araddr, rdata;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, rresp;
  logic        awvalid, awready, wvalid, wlast, wready, bready, bvalid;
  logic [31:0] awaddr, wdata;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [3:0]  wstrb;
  logic        arvalid4, arready4, rready4, rvalid4, rlast4;
  logic [31:0] araddr4, rdata4;
  logic [7:0]  arlen4;
  logic [2:0]  arsize4;
  logic [1:0]  arburst4, rresp4;
  logic        awvalid4, awready4, wvalid4, wlast4, wready4, bready4, bvalid4;
  logic [31:0] awaddr4, wdata4;
  logic [7:0]  awlen4;
  logic [2:0]  awsize4;
  logic [1:0]  awburst4, bresp4;
  logic [3:0]  wstrb4;

  int          checks = 0;
  int          errors = 0;
  int          rr_mode = 0;
  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [7:0]  lens [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd15};

  npc_axi_sram #(.RD_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arready(arready),
    .rready(rready), .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
    .bready(bready), .bvalid(bvalid), .bresp(bresp));

  npc_axi_sram #(.RD_LAT(4)) dut4 (
    .clock(clock), .reset(reset),
    .arvalid(arvalid4), .araddr(araddr4), .arlen(arlen4), .arsize(arsize4), .arburst(arburst4), .arready(arready4),
    .rready(rready4), .rvalid(rvalid4), .rdata(rdata4), .rresp(rresp4), .rlast(rlast4),
    .awvalid(awvalid4), .awaddr(awaddr4), .awlen(awlen4), .awsize(awsize4), .awburst(awburst4), .awready(awready4),
    .wvalid(wvalid4), .wdata(wdata4), .wstrb(wstrb4), .wlast(wlast4), .wready(wready4),
    .bready(bready4), .bvalid(bvalid4), .bresp(bresp4));

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout, got no handshake expected one within bound", name);
    finish_sim();
  endtask

  // Address of beat k computed directly from the burst definition.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst,
                                            input logic [31:0] k);
    logic [31:0] step, total, base;
    step = 32'd1 << size;
    if (burst == 2'd0) return a;
    if (burst == 2'd2 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      total = step * ({24'd0, len} + 32'd1);
      base  = a - (a % total);
      return base + (((a - base) + step * k) % total);
    end
    return a + step * k;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] size);
    return (a < BASE) || (a >= LIMIT) || (size > 3'd2);
  endfunction

  function automatic logic [11:0] widx(input logic [31:0] a);
    return 12'((a - BASE) >> 2);
  endfunction

  task automatic wait_r_done();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (rq.size() != 0) timeout("r_drain");
  endtask

  task automatic read_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input bit wait_done);
    rbeat_t      e;
    logic [31:0] ba;
    int          n;
    for (int k = 0; k <= int'(len); k++) begin
      ba  = beat_addr(a, len, size, burst, 32'(k));
      e.l = (k == int'(len));
      if (is_err(ba, size)) begin
        e.d = '0;
        e.r = 2'b10;
      end else begin
        e.d = ref_mem[widx(ba)];
        e.r = 2'b00;
      end
      rq.push_back(e);
    end
    @(posedge clock); #1;
    arvalid = 1'b1; araddr = a; arlen = len; arsize = size; arburst = burst;
    n = 0;
    do begin @(negedge clock); n++; end while (!arready && n < 100);
    if (!arready) timeout("ar_handshake");
    @(posedge clock); #1;
    arvalid = 1'b0;
    @(negedge clock);
    chk("r_latency", 64'(rvalid), 64'd1);
    if (rr_mode == 2) begin
      for (int k = 1; k <= int'(len); k++) begin
        @(negedge clock);
        chk("r_back_to_back", 64'(rvalid), 64'd1);
      end
    end
    if (wait_done) wait_r_done();
  endtask

  task automatic write_burst(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input int early);
    bit          err;
    bit          lastk;
    logic [31:0] ba;
    int          n;
    err = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      ba    = beat_addr(a, len, size, burst, 32'(k));
      lastk = (early >= 0) ? (k == early) : (k == int'(len));
      if (lastk != (k == int'(len))) err = 1'b1;
      if (is_err(ba, size)) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (ws[k][b]) ref_mem[widx(ba)][8*b +: 8] = wd[k][8*b +: 8];
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    @(posedge clock); #1;
    awvalid = 1'b1; awaddr = a; awlen = len; awsize = size; awburst = burst;
    n = 0;
    do begin @(negedge clock); n++; end while (!awready && n < 100);
    if (!awready) timeout("aw_handshake");
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      if ($urandom_range(0, 2) == 0) begin
        wvalid = 1'b0;
        @(posedge clock); #1;
      end
      wvalid = 1'b1;
      wdata  = wd[k];
      wstrb  = ws[k];
      wlast  = (early >= 0) ? (k == early) : (k == int'(len));
      n = 0;
      do begin @(negedge clock); n++; end while (!wready && n < 100);
      if (!wready) timeout("w_handshake");
      @(posedge clock); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    n = 0;
    while (bq.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (bq.size() != 0) timeout("b_handshake");
  endtask

  initial begin
    rready = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (rr_mode == 2)      rready = 1'b1;
      else if (rr_mode == 1) rready = 1'b0;
      else                   rready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    bready = 1'b0;
    forever begin
      @(posedge clock); #1;
      bready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: scoreboard pops, hold-stability and return-to-idle checks.
  initial begin
    rbeat_t     e, held;
    logic [1:0] eb;
    bit         prev_stall, chk_ar, chk_aw;
    prev_stall = 1'b0; chk_ar = 1'b0; chk_aw = 1'b0; held = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 1'b0; chk_ar = 1'b0; chk_aw = 1'b0;
      end else begin
        if (chk_ar) begin
          chk("r_idle_after_last", 64'({rvalid, rlast, arready}), 64'(3'b001));
          chk_ar = 1'b0;
        end
        if (chk_aw) begin
          chk("w_idle_after_b", 64'({bvalid, awready}), 64'(2'b01));
          chk_aw = 1'b0;
        end
        if (prev_stall) chk("r_hold", 64'({rvalid, rdata, rresp, rlast}), 64'({1'b1, held}));
        if (rvalid && rready) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected: got beat %0h expected none", rdata);
          end else begin
            e = rq.pop_front();
            chk("r_beat", 64'({rdata, rresp, rlast}), 64'(e));
            if (e.l) chk_ar = 1'b1;
          end
        end
        prev_stall = rvalid && !rready;
        held       = {rdata, rresp, rlast};
        if (bvalid && bready) begin
          if (bq.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected: got bresp %0h expected none", bresp);
          end else begin
            eb = bq.pop_front();
            chk("b_resp", 64'(bresp), 64'(eb));
            chk_aw = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    checks++; errors++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    finish_sim();
  end

  initial begin
    int n;
    reset = 1'b1;
    arvalid = 0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1;
    awvalid = 0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1;
    wvalid = 0; wdata = '0; wstrb = '0; wlast = 0;
    arvalid4 = 0; araddr4 = BASE; arlen4 = '0; arsize4 = 3'd2; arburst4 = 2'd1; rready4 = 1'b1;
    awvalid4 = 0; awaddr4 = '0; awlen4 = '0; awsize4 = 3'd2; awburst4 = 2'd1;
    wvalid4 = 0; wdata4 = '0; wstrb4 = '0; wlast4 = 0; bready4 = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_ctl", 64'({arready, awready, wready, rvalid, rlast, rresp, bvalid, bresp}), 64'(10'b11_0000_0000));
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_ctl4", 64'({arready4, awready4, wready4, rvalid4, rlast4, rresp4, bvalid4, bresp4}), 64'(10'b11_0000_0000));
    chk("reset_rdata4", 64'(rdata4), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // Fill the words the bench reads from so every expected value is defined.
    for (int blk = 0; blk < 5; blk++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      write_burst((blk < 4) ? BASE + 32'(blk * 64) : BASE + 32'(4080 * 4), 8'd15, 3'd2, 2'd1, -1);
    end

    rr_mode = 0;
    read_burst(BASE, 8'd0, 3'd2, 2'd1, 1'b1);

    for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
    write_burst(BASE + 32'h10, 8'd3, 3'd2, 2'd1, -1);
    rr_mode = 2;
    read_burst(BASE + 32'h10, 8'd3, 3'd2, 2'd1, 1'b1);
    read_burst(BASE + 32'h18, 8'd3, 3'd2, 2'd2, 1'b1);
    read_burst(BASE + 32'h10, 8'd2, 3'd2, 2'd0, 1'b1);

    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    write_burst(BASE + 32'h20, 8'd0, 3'd2, 2'd1, -1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    write_burst(BASE + 32'h20, 8'd0, 3'd2, 2'd1, -1);
    rr_mode = 1;
    read_burst(BASE + 32'h20, 8'd0, 3'd2, 2'd1, 1'b0);
    repeat (5) begin
      @(negedge clock);
      chk("r_stall_valid", 64'(rvalid), 64'd1);
    end
    rr_mode = 2;
    wait_r_done();

    rr_mode = 0;
    read_burst(32'h7FFF_FFFC, 8'd0, 3'd2, 2'd1, 1'b1);
    wd[0] = $urandom; ws[0] = 4'hF;
    write_burst(LIMIT, 8'd0, 3'd2, 2'd1, -1);
    read_burst(LIMIT - 32'd4, 8'd0, 3'd2, 2'd1, 1'b1);

    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    write_burst(BASE + 32'h40, 8'd3, 3'd2, 2'd1, 1);
    read_burst(BASE + 32'h40, 8'd3, 3'd2, 2'd1, 1'b1);

    @(posedge clock); #1;
    arvalid4 = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!arready4 && n < 100);
    if (!arready4) timeout("ar4_handshake");
    @(posedge clock); #1;
    arvalid4 = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (!rvalid4 && n < 20);
    chk("rd_lat4_cycles", 64'(n), 64'd4);
    chk("rd_lat4_beat", 64'({rresp4, rlast4}), 64'(3'b001));

    rr_mode = 1;
    read_burst(BASE, 8'd7, 3'd2, 2'd1, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_mid_read", 64'({rvalid, rlast, arready}), 64'(3'b001));
    rq.delete();
    @(negedge clock);
    chk("reset_mid_read_hold", 64'(rvalid), 64'd0);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          early;
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 3));
      len   = lens[$urandom_range(0, 5)];
      case ($urandom_range(0, 7))
        6:       a = BASE + 32'($urandom_range(4088, 4097)) * 32'd4;
        7:       a = BASE - 32'($urandom_range(1, 4)) * 32'd4;
        default: a = BASE + 32'($urandom_range(0, 47)) * 32'd4;
      endcase
      if (size < 3'd3) a = a + (32'($urandom_range(0, 3)) & ~((32'd1 << size) - 32'd1));
      rr_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      if ($urandom_range(0, 1) != 0) begin
        read_burst(a, len, size, burst, 1'b1);
      end else begin
        for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15)); end
        early = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 32'(len))) : -1;
        write_burst(a, len, size, burst, early);
      end
    end

    repeat (4) @(negedge clock);
    finish_sim();
  end
endmodule
